// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants and the occupancy encoding for the two-slot skid pipeline register.
package pipe_skid_reg_pkg;

  localparam int DEF_DATA_WIDTH = 96;
  localparam int DEF_CTRL_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// One pipeline slot: valid/ctrl/data register with load, drop and control-clear.
module pipe_slot #(
  parameter int DATA_WIDTH = 96,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  drop_i,
  input  logic                  clr_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Clear beats load: a flushed entry must never leave control bits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: in_ready comes only from registered state,
// flush zeroes control fields and counts discarded entries.
// Handshake: a transfer happens on an edge where valid && ready; valid never waits on ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  discard_cnt,
  output logic [1:0]            dbg_state
);

  skid_state_e state_q;

  logic                  push, pop;
  logic                  main_load, main_drop, skid_load, skid_drop;
  logic                  main_valid, skid_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_data_in;
  logic [1:0]            discard_add;
  logic [CNT_WIDTH+1:0]  discard_sum;
  logic [CNT_WIDTH-1:0]  discard_cnt_q, discard_cnt_d;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign main_load = ((state_q == ST_EMPTY) && push)
                  || ((state_q == ST_ONE) && push && pop)
                  || ((state_q == ST_FULL) && pop);
  assign main_drop = (state_q == ST_ONE) && pop && !push;
  assign skid_load = (state_q == ST_ONE) && push && !pop;
  assign skid_drop = (state_q == ST_FULL) && pop;

  // In FULL the main slot refills from skid; otherwise straight from the input.
  assign main_ctrl_in = (state_q == ST_FULL) ? skid_ctrl : in_ctrl;
  assign main_data_in = (state_q == ST_FULL) ? skid_data : in_data;

  pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
    .clk(clk), .rst(rst), .load_i(main_load), .drop_i(main_drop), .clr_i(flush),
    .ctrl_i(main_ctrl_in), .data_i(main_data_in),
    .valid_o(main_valid), .ctrl_o(main_ctrl), .data_o(main_data)
  );

  pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
    .clk(clk), .rst(rst), .load_i(skid_load), .drop_i(skid_drop), .clr_i(flush),
    .ctrl_i(in_ctrl), .data_i(in_data),
    .valid_o(skid_valid), .ctrl_o(skid_ctrl), .data_o(skid_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_q <= ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_q <= ST_FULL;
          else if (!push && pop) state_q <= ST_EMPTY;
        end
        ST_FULL:  if (pop) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  // Discarded entries = held slots plus the entry being pushed this cycle.
  always_comb begin
    discard_add   = {1'b0, main_valid} + {1'b0, skid_valid} + {1'b0, push};
    discard_sum   = {2'b00, discard_cnt_q} + {{CNT_WIDTH{1'b0}}, discard_add};
    discard_cnt_d = discard_cnt_q;
    if (flush) begin
      if (discard_sum > {2'b00, {CNT_WIDTH{1'b1}}}) discard_cnt_d = {CNT_WIDTH{1'b1}};
      else                                          discard_cnt_d = discard_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) discard_cnt_q <= '0;
    else     discard_cnt_q <= discard_cnt_d;
  end

  assign out_ctrl    = out_valid ? main_ctrl : '0;
  assign out_data    = main_data;
  assign discard_cnt = discard_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96: width of the payload field that is not cleared on flush (pc, operands, immediates, dest).
REQ-002 SHALL have parameter CTRL_WIDTH, default 8: width of the control field that is zeroed on flush or bubble (wb_enable, mem_read, mem_write, is_branch, status_write_enable, ...).
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the discard counter.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: discard all held and incoming entries.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream offers an entry.
REQ-008 SHALL have port in_ready, output, 1 bit: stage can accept an entry.
REQ-009 SHALL have port in_ctrl, input, CTRL_WIDTH bits: incoming control field.
REQ-010 SHALL have port in_data, input, DATA_WIDTH bits: incoming payload field.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes the head.
REQ-013 SHALL have port out_ctrl, output, CTRL_WIDTH bits: head control field.
REQ-014 SHALL have port out_data, output, DATA_WIDTH bits: head payload field.
REQ-015 SHALL have port discard_cnt, output, CNT_WIDTH bits: saturating count of flushed entries.

Function
REQ-016 SHALL hold two slots, main (drives out_*) and skid, with states EMPTY (0 entries), ONE (main valid) and FULL (both valid).
REQ-017 SHALL drive in_ready = (state != FULL) from registered state only, with no combinational path from out_ready to in_ready.
REQ-018 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready, with out_valid = (state != EMPTY).
REQ-019 SHALL make an entry pushed at edge N visible on out_* after edge N (1-cycle latency) when in EMPTY.
REQ-020 SHALL apply these transitions:
  - EMPTY: push -> ONE (load main).
  - ONE: push && pop -> ONE (main <= input); push only -> FULL (load skid); pop only -> EMPTY.
  - FULL: pop -> ONE (main <= skid); otherwise stay in FULL.
REQ-021 SHALL preserve FIFO order; no entry is duplicated or lost except by flush.
REQ-022 SHALL force out_ctrl to all zeros whenever out_valid = 0 (bubble); out_data holds its last value.
REQ-023 SHALL, on flush = 1 (and rst = 0), move to EMPTY at the next edge, zero both slots' control fields, leave data fields unchanged and ignore any pop.
REQ-024 SHALL add to discard_cnt, on a flush cycle, the number of valid slots plus 1 if push is asserted that cycle (0..3), saturating at all ones.
REQ-025 SHALL have discard_cnt hold its value when it is saturated and unchanged outside flush cycles.

Reset
REQ-026 SHALL have rst take priority over flush and all handshakes.
REQ-027 SHALL, on rst, set state = EMPTY, zero both slots' ctrl and data fields, and zero discard_cnt.
REQ-028 SHALL therefore drive out_valid = 0, out_ctrl = 0, out_data = 0 and in_ready = 1 in the first cycle after reset.
REQ-029 SHALL let rst asserted mid-transfer drop all held entries without counting them in discard_cnt.

Structure
REQ-030 SHALL place the state encoding (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) and the default width constants in the shared ISA package/header.
REQ-031 SHALL use one sub-module, pipe_slot: a single valid/ctrl/data register with load and ctrl-clear inputs, instantiated twice (main, skid).
REQ-032 SHALL keep the block purely synchronous, with no latches and no multicycle paths.

Verification
REQ-033 SHALL have the bench check streaming: out_ready = 1, push 0x11, 0x22, 0x33 on back-to-back cycles -> outputs appear 1 cycle later in order, in_ready constantly 1.
REQ-034 SHALL have the bench check backpressure: out_ready = 0, push 0xA1 then 0xA2 -> state FULL, in_ready = 0; raise out_ready -> 0xA1 then 0xA2 appear, in_ready = 1 after the first pop.
REQ-035 SHALL have the bench check flush in FULL with in_valid = 1 simultaneous: discard_cnt increments by 2 (in_ready = 0), out_valid = 0, out_ctrl = 0, data unchanged next cycle.
REQ-036 SHALL have the bench check flush in ONE with push: discard_cnt += 2; with CNT_WIDTH = 2 starting at 3 -> stays 3.
REQ-037 SHALL have the bench check rst and flush together in FULL: all outputs reset, discard_cnt = 0.
REQ-038 SHALL have the bench check the pop/push simultaneous case in ONE: main is replaced by the input the same edge, state stays ONE, no skid load.
